frame_animator: RTL and testbench



---
 rtl/frame_animator_if.sv | 19 +
 rtl/frame_animator.sv | 174 +++++++++++++++++
 tb/tb_frame_animator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_animator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_animator_if                                         |
// | Purpose  : Frame hand-off between the animator and the strip sender.  |
// |            go requests a transfer, frame carries the GRB pattern,     |
// |            ready is high while the sender is idle.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface frame_animator_if #(
  parameter int NUM_LEDS = 5
);
  logic                    go;
  logic                    ready;
  logic [24*NUM_LEDS-1:0]  frame;

  modport master (output go, output frame, input ready);
  modport slave  (input go, input frame, output ready);
endinterface
`default_nettype wire

// File: rtl/frame_animator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_animator                                            |
// | Purpose  : Single-LED cursor animation for a WS2812B strip. Steps a   |
// |            lit pixel along the strip, applies button-driven direction |
// |            and brightness, and hands frames to the strip sender.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module frame_animator #(
  parameter int NUM_LEDS = 5,
  parameter int TICK_DIV = 1000000
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic [11:0]  color,
  input  wire logic [2:0]   speed,
  input  wire logic         left,
  input  wire logic         right,
  input  wire logic         up,
  input  wire logic         down,
  frame_animator_if.master  snd,
  output logic [7:0]        disp
);

  localparam int              c_frame_w   = 24 * NUM_LEDS;
  localparam int              c_tick_w    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [2:0]      c_last_pos  = 3'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_btn_s1, r_btn_s2, r_btn_s3;
  logic [3:0]             w_btn_rise;
  logic [c_tick_w-1:0]    r_tick_cnt;
  logic                   w_tick;
  logic [2:0]             r_step_cnt;
  logic                   w_step;
  logic [2:0]             r_pos, w_pos_nxt;
  logic                   r_dir, w_dir_nxt;        // 1 = right
  logic [3:0]             r_br, w_br_nxt;
  logic [11:0]            r_color;
  logic                   r_dirty;
  logic                   w_change;
  logic                   w_latch;
  logic                   r_go;
  logic [c_frame_w-1:0]   r_frame;
  logic [c_frame_w-1:0]   w_pattern;
  logic [23:0]            w_lit;
  logic [7:0]             r_disp;

  // Button order in the vectors: {left, right, up, down}
  // Two-stage synchroniser followed by an edge register for each button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_btn_s3 <= '0;
    end else begin
      r_btn_s1 <= {left, right, up, down};
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
    end
  end

  assign w_btn_rise = r_btn_s2 & ~r_btn_s3;

  // Free-running prescaler producing a one-cycle animation tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
  end

  assign w_tick = (r_tick_cnt == c_tick_last);
  assign w_step = w_tick && (speed != 3'd0) && (r_step_cnt >= (3'd7 - speed));

  // Step counter: interval of 8-speed ticks, frozen while speed is zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             r_step_cnt <= '0;
    else if (w_tick && (speed != 3'd0))     r_step_cnt <= w_step ? 3'd0 : r_step_cnt + 3'd1;
  end

  // Next direction, brightness and position; simultaneous opposing presses cancel
  always_comb begin
    w_dir_nxt = r_dir;
    if (w_btn_rise[3] && !w_btn_rise[2])      w_dir_nxt = 1'b0;
    else if (w_btn_rise[2] && !w_btn_rise[3]) w_dir_nxt = 1'b1;

    w_br_nxt = r_br;
    if (w_btn_rise[1] && !w_btn_rise[0] && (r_br != 4'd15))     w_br_nxt = r_br + 4'd1;
    else if (w_btn_rise[0] && !w_btn_rise[1] && (r_br != 4'd1)) w_br_nxt = r_br - 4'd1;

    if (r_dir) w_pos_nxt = (r_pos == c_last_pos) ? 3'd0 : r_pos + 3'd1;
    else       w_pos_nxt = (r_pos == 3'd0) ? c_last_pos : r_pos - 3'd1;
  end

  assign w_change = (color != r_color) || (w_dir_nxt != r_dir) ||
                    (w_br_nxt != r_br) || w_step;

  // Animation state; a new event keeps dirty set even when a frame is latched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos   <= 3'd0;
      r_dir   <= 1'b1;
      r_br    <= 4'd4;
      r_color <= 12'h000;
      r_dirty <= 1'b1;
    end else begin
      r_color <= color;
      r_dir   <= w_dir_nxt;
      r_br    <= w_br_nxt;
      if (w_step) r_pos <= w_pos_nxt;
      if (w_change)     r_dirty <= 1'b1;
      else if (w_latch) r_dirty <= 1'b0;
    end
  end

  // Lit pixel: each colour nibble scaled by brightness, G byte first
  assign w_lit = {{4'd0, r_color[11:8]} * {4'd0, r_br},
                  {4'd0, r_color[7:4]}  * {4'd0, r_br},
                  {4'd0, r_color[3:0]}  * {4'd0, r_br}};

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_pix
    assign w_pattern[c_frame_w-1-24*k -: 24] = (r_pos == 3'(k)) ? w_lit : 24'h000000;
  end

  // Handshake state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Handshake next state; a latch waits one cycle while a new colour is
  // being registered so a frame never ships a stale colour
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_dirty && snd.ready && (color == r_color)) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (!snd.ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (snd.ready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered go, frame capture and display value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_go    <= 1'b0;
      r_frame <= '0;
      r_disp  <= 8'h40;
    end else begin
      r_go   <= (w_state_nxt == S_ISSUE);
      r_disp <= {r_br, 1'b0, r_pos};
      if (w_latch) r_frame <= w_pattern;
    end
  end

  assign snd.go    = r_go;
  assign snd.frame = r_frame;
  assign disp      = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_frame_animator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_frame_animator                                         |
// | Purpose  : Directed self-checking bench for frame_animator with a     |
// |            simple strip-sender model driving ready.                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_frame_animator;

  localparam int NL = 5;
  localparam int FW = 24 * NL;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] color;
  logic [2:0]  speed;
  logic        left, right, up, down;
  logic [7:0]  disp;
  logic        go;

  logic auto_snd   = 1'b1;
  logic auto_ready = 1'b1;
  logic man_ready  = 1'b1;

  int checks     = 0;
  int failures   = 0;
  int gocount    = 0;
  int proto_err  = 0;
  logic prev_go  = 1'b0;

  frame_animator_if #(.NUM_LEDS(NL)) sif ();

  assign sif.ready = auto_snd ? auto_ready : man_ready;
  assign go        = sif.go;

  frame_animator #(.NUM_LEDS(NL), .TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .color (color),
    .speed (speed),
    .left  (left),
    .right (right),
    .up    (up),
    .down  (down),
    .snd   (sif),
    .disp  (disp)
  );

  always #5 clk = ~clk;

  // Sender model: ready drops 2 cycles after go is seen, rises 10 cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (auto_snd && go === 1'b1) begin
        repeat (2) @(negedge clk);
        auto_ready = 1'b0;
        repeat (10) @(negedge clk);
        auto_ready = 1'b1;
      end
    end
  end

  // Protocol monitor: counts go pulses; go must be low whenever ready was sampled low
  always begin
    @(posedge clk);
    #2;
    if (go === 1'b1 && prev_go !== 1'b1) gocount++;
    if (go === 1'b1 && sif.ready === 1'b0) proto_err++;
    prev_go = go;
  end

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_go(input string nm);
    int  k;
    bit  seen;
    k = 0;
    while (go !== 1'b0 && k < 40) begin @(negedge clk); k++; end
    k = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (go === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: go got 0 expected 1 within 60 cycles", nm);
    end
  endtask

  task automatic press(input logic [3:0] m);
    {left, right, up, down} = m;
    repeat (4) @(negedge clk);
    {left, right, up, down} = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  // Wait for n changes of the displayed position, then freeze stepping
  task automatic count_steps(input int n, input string nm);
    logic [2:0] last;
    int seen;
    last = disp[2:0];
    seen = 0;
    for (int k = 0; k < 120 && seen < n; k++) begin
      @(negedge clk);
      if (disp[2:0] != last) begin
        last = disp[2:0];
        seen++;
        if (seen == n) speed = 3'd0;
      end
    end
    speed = 3'd0;
    checks++;
    if (seen != n) begin
      failures++;
      $display("FAIL %s: steps got %0d expected %0d", nm, seen, n);
    end
  endtask

  typedef struct {
    logic [11:0] col;
    logic [23:0] led0;
  } vec_t;

  vec_t       vecs[7];
  logic [2:0] seq[6];
  logic [2:0] exp_seq[6];
  int         n;
  int         g0;
  logic [2:0] last;

  initial begin
    vecs[0] = '{12'h123, 24'h04080C};
    vecs[1] = '{12'hABC, 24'h282C30};
    vecs[2] = '{12'h0F0, 24'h003C00};
    vecs[3] = '{12'h00F, 24'h00003C};
    vecs[4] = '{12'h111, 24'h040404};
    vecs[5] = '{12'h000, 24'h000000};
    vecs[6] = '{12'hFFF, 24'h3C3C3C};
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd1; exp_seq[2] = 3'd2;
    exp_seq[3] = 3'd3; exp_seq[4] = 3'd4; exp_seq[5] = 3'd0;

    reset = 1'b0;
    color = 12'hF00;
    speed = 3'd0;
    {left, right, up, down} = 4'b0000;

    // Reset state and first frame
    repeat (5) @(negedge clk);
    check("rst_go",    FW'(go), FW'(1'b0));
    check("rst_frame", sif.frame, '0);
    check("rst_disp",  FW'(disp), FW'(8'h40));
    reset = 1'b1;
    wait_go("first_go");
    check("first_frame", sif.frame, {24'h3C0000, 96'h0});
    check("first_disp",  FW'(disp), FW'(8'h40));
    repeat (30) @(negedge clk);
    check("first_go_count", FW'(gocount), FW'(1));

    // Colour table at br=4, pos=0
    for (int i = 0; i < 7; i++) begin
      color = vecs[i].col;
      wait_go($sformatf("col%0d_go", i));
      check($sformatf("col%0d_frame", i), sif.frame, {vecs[i].led0, 96'h0});
      repeat (16) @(negedge clk);
    end

    // Brightness: cancel, saturate high, saturate low
    color = 12'hF00;
    wait_go("bright_go");
    repeat (16) @(negedge clk);
    press(4'b0011);
    repeat (4) @(negedge clk);
    check("updown_cancel", FW'(disp), FW'(8'h40));
    for (int i = 0; i < 12; i++) press(4'b0010);
    repeat (60) @(negedge clk);
    check("br_max_disp",  FW'(disp), FW'(8'hF0));
    check("br_max_frame", sif.frame, {24'hE10000, 96'h0});
    for (int i = 0; i < 20; i++) press(4'b0001);
    repeat (60) @(negedge clk);
    check("br_min_disp",  FW'(disp), FW'(8'h10));
    check("br_min_frame", sif.frame, {24'h0F0000, 96'h0});

    // Stepping right with wrap
    for (int i = 0; i < 6; i++) seq[i] = 3'd7;
    speed = 3'd7;
    last = disp[2:0];
    seq[0] = last;
    n = 1;
    for (int k = 0; k < 100 && n < 6; k++) begin
      @(negedge clk);
      if (disp[2:0] != last) begin
        last = disp[2:0];
        seq[n] = last;
        n++;
        if (n == 6) speed = 3'd0;
      end
    end
    speed = 3'd0;
    for (int i = 0; i < 6; i++)
      check($sformatf("step_pos%0d", i), FW'(seq[i]), FW'(exp_seq[i]));
    repeat (20) @(negedge clk);
    check("frozen_disp", FW'(disp), FW'(8'h10));
    repeat (30) @(negedge clk);
    check("step_frame", sif.frame, {24'h0F0000, 96'h0});

    // Left wrap from pos 0
    press(4'b1000);
    speed = 3'd7;
    count_steps(1, "left_step");
    check("left_wrap_disp", FW'(disp), FW'(8'h14));
    repeat (40) @(negedge clk);
    check("left_wrap_frame", sif.frame, {96'h0, 24'h0F0000});

    // Coalescing while the sender holds ready low
    auto_snd  = 1'b0;
    man_ready = 1'b1;
    color = 12'h0F0;
    wait_go("coal_go0");
    repeat (2) @(negedge clk);
    man_ready = 1'b0;
    repeat (3) @(negedge clk);
    g0 = gocount;
    speed = 3'd7;
    count_steps(3, "coal_steps");
    color = 12'h00F;
    repeat (5) @(negedge clk);
    check("coal_no_go_low", FW'(gocount), FW'(g0));
    man_ready = 1'b1;
    wait_go("coal_go1");
    check("coal_frame", sif.frame, {24'h0, 24'h00000F, 72'h0});
    check("coal_disp",  FW'(disp), FW'(8'h11));
    repeat (2) @(negedge clk);
    man_ready = 1'b0;
    repeat (3) @(negedge clk);
    man_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("coal_one_go", FW'(gocount), FW'(g0 + 1));

    // Asynchronous reset during ISSUE
    color = 12'hF00;
    wait_go("areset_go");
    #2 reset = 1'b0;
    #1;
    check("areset_go_low", FW'(go), FW'(1'b0));
    check("areset_frame",  sif.frame, '0);
    check("areset_disp",   FW'(disp), FW'(8'h40));
    @(negedge clk);
    reset    = 1'b1;
    auto_snd = 1'b1;
    wait_go("areset_resend");
    check("areset_resend_frame", sif.frame, {24'h3C0000, 96'h0});
    check("areset_resend_disp",  FW'(disp), FW'(8'h40));
    repeat (20) @(negedge clk);

    check("protocol", FW'(proto_err), FW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
